// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/ack fetch to
// instruction memory and delivers {PC+PC_INC, instruction} into the IF/ID register.
module fetch_stage #(
  parameter int              PC_W     = 16,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              PC_INC   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              ifid_load,
  output logic              ifid_flush,
  output logic [PC_W-1:0]   pcp_out,
  output logic [INST_W-1:0] inst_out
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     req_addr_q, req_addr_d;
  logic [INST_W-1:0]   hold_inst_q, hold_inst_d;
  logic [PC_W-1:0]     hold_pcp_q, hold_pcp_d;

  logic                req_c;
  logic                load_c;
  logic                flush_c;
  logic [PC_W-1:0]     pcp_c;
  logic [INST_W-1:0]   inst_c;
  logic [PC_W-1:0]     seq_pcp;

  // Address wraps modulo 2^PC_W through plain truncating addition.
  assign seq_pcp = req_addr_q + PC_STEP;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    hold_inst_d = hold_inst_q;
    hold_pcp_d  = hold_pcp_q;
    req_c       = 1'b0;
    load_c      = 1'b0;
    flush_c     = 1'b0;
    pcp_c       = hold_pcp_q;
    inst_c      = hold_inst_q;

    case (state_q)
      ST_REQ: begin
        req_c = 1'b1;
        if (branch_taken) begin
          flush_c = 1'b1;
          pc_d    = branch_target;
          if (imem_ack) begin
            req_addr_d = branch_target;
            state_d    = ST_REQ;
          end else begin
            // The in-flight handshake must complete; its data is thrown away.
            state_d = ST_DRAIN;
          end
        end else if (imem_ack) begin
          pc_d       = seq_pcp;
          req_addr_d = seq_pcp;
          if (!stall) begin
            load_c = 1'b1;
            pcp_c  = seq_pcp;
            inst_c = imem_rdata;
          end else begin
            hold_inst_d = imem_rdata;
            hold_pcp_d  = seq_pcp;
            state_d     = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (branch_taken) begin
          flush_c    = 1'b1;
          pc_d       = branch_target;
          req_addr_d = branch_target;
          state_d    = ST_REQ;
        end else if (!stall) begin
          load_c  = 1'b1;
          state_d = ST_REQ;
        end
      end

      ST_DRAIN: begin
        req_c = 1'b1;
        if (branch_taken) begin
          flush_c = 1'b1;
          pc_d    = branch_target;
        end
        // A redirect landing on the same cycle as the ack wins via pc_d.
        if (imem_ack) begin
          req_addr_d = pc_d;
          state_d    = ST_REQ;
        end
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      hold_inst_q <= '0;
      hold_pcp_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      hold_inst_q <= hold_inst_d;
      hold_pcp_q  <= hold_pcp_d;
    end
  end

  assign imem_req   = rst & req_c;
  assign imem_addr  = rst ? req_addr_q : '0;
  assign ifid_load  = rst & load_c;
  assign ifid_flush = rst & flush_c;
  assign pcp_out    = rst ? pcp_c : '0;
  assign inst_out   = rst ? inst_c : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations
// plus randomized stall/redirect/latency traffic checked against a transaction model.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ifid_load;
  logic        ifid_flush;
  logic [15:0] pcp_out;
  logic [31:0] inst_out;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .ifid_load     (ifid_load),
    .ifid_flush    (ifid_flush),
    .pcp_out       (pcp_out),
    .inst_out      (inst_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pcp;
    logic [31:0] inst;
  } ent_t;

  ent_t load_log[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   started  = 0;
  bit   echo     = 1;
  int   fixed_wait = 0;
  int   wait_left  = -1;

  // Memory contents: either the address itself or a scrambled word.
  function automatic logic [31:0] memf(input logic [15:0] a);
    if (echo) return {16'h0000, a};
    return {a, ~a} ^ 32'hA5C3_0F96;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_log(input string name, input int idx, input logic [15:0] pcp,
                         input logic [31:0] inst);
    n_checks++;
    if (idx >= load_log.size()) begin
      n_fail++;
      $display("FAIL %s: got %0d loads expected more than %0d", name, load_log.size(), idx);
    end else begin
      chk({name, "_pcp"}, {16'h0, load_log[idx].pcp}, {16'h0, pcp});
      chk({name, "_inst"}, load_log[idx].inst, inst);
    end
  endtask

  // One clock: drive control inputs, then answer the memory handshake.
  task automatic step(input logic r, input logic s, input logic b, input logic [15:0] t);
    @(posedge clk);
    #1;
    rst = r; stall = s; branch_taken = b; branch_target = t;
    started = 1;
    #1;
    if (imem_req) begin
      if (wait_left < 0) wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
      if (wait_left == 0) begin
        imem_ack  = 1'b1;
        wait_left = -1;
      end else begin
        imem_ack = 1'b0;
        wait_left--;
      end
    end else begin
      imem_ack = r ? 1'b0 : 1'($urandom_range(0, 1));
    end
    imem_rdata = memf(imem_addr);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    wait_left = -1;
    load_log.delete();
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Transaction model: outstanding fetch address, optional buffered word,
  // and whether the outstanding fetch has been superseded by a redirect.
  logic [15:0] m_fetch_addr = 16'h0;
  logic [15:0] m_target     = 16'h0;
  logic        m_stale      = 1'b0;
  logic        m_buf_valid  = 1'b0;
  logic [15:0] m_buf_pcp    = 16'h0;
  logic [31:0] m_buf_inst   = 32'h0;

  always @(negedge clk) begin
    logic        e_load;
    logic [15:0] e_pcp;
    logic [31:0] e_inst;
    if (started) begin
      if (!rst) begin
        chk("rst_req",   {31'h0, imem_req},   32'h0);
        chk("rst_addr",  {16'h0, imem_addr},  32'h0);
        chk("rst_load",  {31'h0, ifid_load},  32'h0);
        chk("rst_flush", {31'h0, ifid_flush}, 32'h0);
        chk("rst_pcp",   {16'h0, pcp_out},    32'h0);
        chk("rst_inst",  inst_out,            32'h0);
        m_fetch_addr = 16'h0;
        m_target     = 16'h0;
        m_stale      = 1'b0;
        m_buf_valid  = 1'b0;
      end else begin
        chk("imem_req", {31'h0, imem_req}, {31'h0, !m_buf_valid});
        if (!m_buf_valid) chk("imem_addr", {16'h0, imem_addr}, {16'h0, m_fetch_addr});
        chk("ifid_flush", {31'h0, ifid_flush}, {31'h0, branch_taken});

        e_load = 1'b0; e_pcp = 16'h0; e_inst = 32'h0;
        if (!branch_taken && !stall) begin
          if (m_buf_valid) begin
            e_load = 1'b1; e_pcp = m_buf_pcp; e_inst = m_buf_inst;
          end else if (imem_ack && !m_stale) begin
            e_load = 1'b1; e_pcp = m_fetch_addr + 16'd4; e_inst = memf(m_fetch_addr);
          end
        end
        chk("ifid_load", {31'h0, ifid_load}, {31'h0, e_load});
        if (e_load) begin
          chk("pcp_out", {16'h0, pcp_out}, {16'h0, e_pcp});
          chk("inst_out", inst_out, e_inst);
        end
        if (ifid_load) load_log.push_back('{pcp: pcp_out, inst: inst_out});

        if (m_buf_valid) begin
          if (branch_taken) begin
            m_buf_valid  = 1'b0;
            m_fetch_addr = branch_target;
          end else if (!stall) begin
            m_buf_valid = 1'b0;
          end
        end else if (m_stale) begin
          if (branch_taken) m_target = branch_target;
          if (imem_ack) begin
            m_stale      = 1'b0;
            m_fetch_addr = m_target;
          end
        end else if (imem_ack) begin
          if (branch_taken) begin
            m_fetch_addr = branch_target;
          end else begin
            if (stall) begin
              m_buf_valid = 1'b1;
              m_buf_pcp   = m_fetch_addr + 16'd4;
              m_buf_inst  = memf(m_fetch_addr);
            end
            m_fetch_addr = m_fetch_addr + 16'd4;
          end
        end else if (branch_taken) begin
          m_stale  = 1'b1;
          m_target = branch_target;
        end
      end
    end
  end

  initial begin
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;

    // Zero-wait echo memory: one load per cycle.
    echo = 1; fixed_wait = 0;
    do_reset();
    repeat (3) step(1'b1, 1'b0, 1'b0, 16'h0);
    settle();
    chk_log("zw0", 0, 16'h0004, 32'h0);
    chk_log("zw1", 1, 16'h0008, 32'h4);
    chk_log("zw2", 2, 16'h000C, 32'h8);

    // Two wait states: three fetches in nine cycles.
    fixed_wait = 2;
    do_reset();
    repeat (9) step(1'b1, 1'b0, 1'b0, 16'h0);
    settle();
    chk("w2_loads", load_log.size(), 32'd3);
    chk_log("w2_third", 2, 16'h000C, 32'h8);

    // Stall at ack of 0x10 for three cycles.
    fixed_wait = 0;
    do_reset();
    repeat (4) step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("hold_req", {31'h0, imem_req}, 32'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("after_hold_addr", {16'h0, imem_addr}, 32'h14);
    settle();
    chk_log("hold_rel", 4, 16'h0014, 32'h10);

    // Redirect while a fetch is waiting: stale ack must not load.
    fixed_wait = 2;
    do_reset();
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b1, 16'h0040);
    chk("drain_flush", {31'h0, ifid_flush}, 32'h1);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("drain_next_addr", {16'h0, imem_addr}, 32'h40);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    settle();
    chk("drain_loads", load_log.size(), 32'd1);
    chk_log("drain_tgt", 0, 16'h0044, 32'h40);

    // Redirect with stall while holding a word.
    fixed_wait = 0;
    do_reset();
    step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b1, 16'h0080);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    settle();
    chk("holdbr_loads", load_log.size(), 32'd1);
    chk_log("holdbr_tgt", 0, 16'h0084, 32'h80);

    // PC wrap at 0xFFFC.
    do_reset();
    step(1'b1, 1'b0, 1'b1, 16'hFFFC);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("wrap_addr", {16'h0, imem_addr}, 32'h0);
    settle();
    chk_log("wrap0", 0, 16'h0000, 32'hFFFC);
    chk_log("wrap1", 1, 16'h0004, 32'h0);

    // Reset in the middle of a waiting fetch.
    do_reset();
    repeat (3) step(1'b1, 1'b0, 1'b0, 16'h0);
    fixed_wait = 3;
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("midwait_addr", {16'h0, imem_addr}, 32'hC);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("rst_restart_req", {31'h0, imem_req}, 32'h1);
    chk("rst_restart_addr", {16'h0, imem_addr}, 32'h0);

    // Randomized traffic against the model.
    echo = 0; fixed_wait = -1;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic        r, s, b;
      logic [15:0] t;
      r = ($urandom_range(0, 99) != 0);
      s = ($urandom_range(0, 99) < 30);
      b = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 7) == 0) t = 16'hFFF0 + 16'($urandom_range(0, 3) * 4);
      else t = {14'($urandom_range(0, 16383)), 2'b00};
      step(r, s, b, t);
    end
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
